// File: rtl/ski_heap_port.sv
// ski_heap_port: heap-memory stage downstream of the SKI reduction step.
// Serves one cell read or write per cycle and injects the root term after
// reset. It also tracks the halt state, a sticky out-of-range error flag and
// the heap high-water mark.
// Optional build macro: HEAP_CLEAR_EN. When defined, reset first sweeps zeros
// into every heap cell (CLEAR state) before waiting for the boot term.
module ski_heap_port #(
  parameter int ADDR_W = 10,
  parameter int TERM_W = 63
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic                  boot_valid_i,
  input  logic [TERM_W-1:0]     boot_term_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [29:0]           req_addr_i,
  input  logic [2*TERM_W-1:0]   req_wdata_i,
  input  logic                  halt_i,
  output logic [2*TERM_W+1:0]   rsp_o,
  output logic                  ready_o,
  output logic                  halted_o,
  output logic                  err_o,
  output logic [29:0]           hiwater_o
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam int          CELL_W  = 2 * TERM_W;
  localparam logic [29:0] DEPTH_A = 30'(DEPTH);

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_ROOT = 2'b01;
  localparam logic [1:0] TAG_CELL = 2'b10;
  localparam logic [1:0] TAG_ERR  = 2'b11;

`ifdef HEAP_CLEAR_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;
  localparam state_t RESET_STATE = ST_BOOT;
`endif

  state_t              state_q, state_d;
  logic [1:0]          tag_q, tag_d;
  logic [TERM_W-1:0]   term_q, term_d;
  logic                err_q, err_d;
  logic [29:0]         hiwater_q, hiwater_d;

  // Heap storage and its registered read port. The response payload for a
  // cell read comes straight out of rd_data_q, so the read costs one cycle.
  logic [CELL_W-1:0]   mem_q [DEPTH];
  logic [CELL_W-1:0]   rd_data_q;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [CELL_W-1:0]   mem_wdata;

`ifdef HEAP_CLEAR_EN
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
`endif

  logic                addr_oor;
  logic [ADDR_W-1:0]   req_idx;
  logic [29:0]         addr_inc;

  assign addr_oor = (req_addr_i >= DEPTH_A);
  assign req_idx  = req_addr_i[ADDR_W-1:0];
  assign addr_inc = req_addr_i + 30'd1;

  // Control state, response tag, root term and status registers.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= RESET_STATE;
      tag_q     <= TAG_NONE;
      term_q    <= '0;
      err_q     <= 1'b0;
      hiwater_q <= '0;
`ifdef HEAP_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      term_q    <= term_d;
      err_q     <= err_d;
      hiwater_q <= hiwater_d;
`ifdef HEAP_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Next-state, response selection and memory port control.
  always_comb begin
    state_d   = state_q;
    tag_d     = TAG_NONE;
    term_d    = term_q;
    err_d     = err_q;
    hiwater_d = hiwater_q;
    mem_we    = 1'b0;
    mem_addr  = req_idx;
    mem_wdata = req_wdata_i;
`ifdef HEAP_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif

    case (state_q)
`ifdef HEAP_CLEAR_EN
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_BOOT;
        end
      end
`endif
      ST_BOOT: begin
        if (boot_valid_i) begin
          tag_d   = TAG_ROOT;
          term_d  = boot_term_i;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A halt in the same cycle as a request wins and drops the request.
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (req_valid_i) begin
          if (addr_oor) begin
            tag_d = TAG_ERR;
            err_d = 1'b1;
          end else if (req_we_i) begin
            mem_we = 1'b1;
            if (addr_inc > hiwater_q) begin
              hiwater_d = addr_inc;
            end
          end else begin
            tag_d = TAG_CELL;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Single-port synchronous RAM; the read register is not reset because it
  // is only visible when the registered tag says a cell read is pending.
  always_ff @(posedge system1000) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
    rd_data_q <= mem_q[mem_addr];
  end

  // Assemble the response word from registered fields only.
  always_comb begin
    rsp_o = '0;
    case (tag_q)
      TAG_ROOT: rsp_o = {TAG_ROOT, term_q, {TERM_W{1'b0}}};
      TAG_CELL: rsp_o = {TAG_CELL, rd_data_q};
      TAG_ERR:  rsp_o = {TAG_ERR, {CELL_W{1'b0}}};
      default:  rsp_o = '0;
    endcase
  end

  assign ready_o   = (state_q == ST_RUN);
  assign halted_o  = (state_q == ST_HALT);
  assign err_o     = err_q;
  assign hiwater_o = hiwater_q;

endmodule

// File: tb/tb_ski_heap_port.sv
// Self-checking bench for ski_heap_port: directed vector table, randomized
// traffic against a behavioural heap model, and hand-written halt and
// asynchronous-reset sequences.
module tb_ski_heap_port;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic          clk;
  logic          rstn;
  logic          boot_valid;
  logic [62:0]   boot_term;
  logic          req_valid;
  logic          req_we;
  logic [29:0]   req_addr;
  logic [125:0]  req_wdata;
  logic          halt;
  logic [127:0]  rsp;
  logic          ready;
  logic          halted;
  logic          err;
  logic [29:0]   hiwater;

  int checks   = 0;
  int failures = 0;

  ski_heap_port #(.ADDR_W(ADDR_W), .TERM_W(63)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .boot_valid_i    (boot_valid),
    .boot_term_i     (boot_term),
    .req_valid_i     (req_valid),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .halt_i          (halt),
    .rsp_o           (rsp),
    .ready_o         (ready),
    .halted_o        (halted),
    .err_o           (err),
    .hiwater_o       (hiwater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit           bv;
    logic [62:0]  bt;
    bit           rv;
    bit           we;
    logic [29:0]  addr;
    logic [125:0] wd;
    bit           h;
    logic [127:0] rsp;
    bit           rdy;
    bit           err;
    logic [29:0]  hi;
  } vec_t;

  // Behavioural heap model: 0 = waiting for boot, 1 = running, 2 = halted.
  int           m_state;
  logic [125:0] m_mem [DEPTH];
  bit           m_wr  [DEPTH];
  bit           m_err;
  logic [29:0]  m_hi;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit bv, logic [62:0] bt, bit rv, bit we, logic [29:0] addr,
                               logic [125:0] wd, bit h, logic [127:0] r, bit rdy, bit e,
                               logic [29:0] hi);
    vec_t v;
    v.bv = bv; v.bt = bt; v.rv = rv; v.we = we; v.addr = addr; v.wd = wd; v.h = h;
    v.rsp = r; v.rdy = rdy; v.err = e; v.hi = hi;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_err   = 1'b0;
    m_hi    = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef HEAP_CLEAR_EN
      m_wr[i]  = 1'b1;
      m_mem[i] = '0;
`else
      m_wr[i]  = 1'b0;
`endif
    end
  endtask

  // One clock of stimulus. Expected values come from the table when use_tbl
  // is set, otherwise from the behavioural model; the model always advances.
  task automatic cyc(input vec_t v, input bit use_tbl, input string nm);
    logic [127:0] er;
    bit           known;
    int           ai;
    boot_valid = v.bv; boot_term = v.bt; req_valid = v.rv; req_we = v.we;
    req_addr = v.addr; req_wdata = v.wd; halt = v.h;
    er    = '0;
    known = 1'b1;
    if (m_state == 0) begin
      if (v.bv) begin
        er      = {2'b01, v.bt, 63'b0};
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (v.h) begin
        m_state = 2;
      end else if (v.rv) begin
        if (v.addr >= 30'(DEPTH)) begin
          er    = {2'b11, 126'b0};
          m_err = 1'b1;
        end else begin
          ai = int'(v.addr);
          if (v.we) begin
            m_mem[ai] = v.wd;
            m_wr[ai]  = 1'b1;
            if (v.addr + 30'd1 > m_hi) m_hi = v.addr + 30'd1;
          end else if (m_wr[ai]) begin
            er = {2'b10, m_mem[ai]};
          end else begin
            known = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (use_tbl) begin
      chk({nm, " rsp"},     rsp,           v.rsp);
      chk({nm, " ready"},   128'(ready),   128'(v.rdy));
      chk({nm, " halted"},  128'(halted),  128'(0));
      chk({nm, " err"},     128'(err),     128'(v.err));
      chk({nm, " hiwater"}, 128'(hiwater), 128'(v.hi));
    end else begin
      if (known) chk({nm, " rsp"}, rsp, er);
      chk({nm, " ready"},   128'(ready),   128'(m_state == 1));
      chk({nm, " halted"},  128'(halted),  128'(m_state == 2));
      chk({nm, " err"},     128'(err),     128'(m_err));
      chk({nm, " hiwater"}, 128'(hiwater), 128'(m_hi));
    end
    $display("txn %-8s bv=%0d rv=%0d we=%0d addr=%0d halt=%0d rsp=%h hi=%0d err=%0d",
             nm, v.bv, v.rv, v.we, v.addr, v.h, rsp, hiwater, err);
  endtask

  task automatic idle_inputs();
    boot_valid = 1'b0; boot_term = '0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; halt = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    idle_inputs();
    rstn = 1'b0;
    #1;
    chk({nm, " rst rsp"},   rsp,           128'(0));
    chk({nm, " rst ready"}, 128'(ready),   128'(0));
    chk({nm, " rst err"},   128'(err),     128'(0));
    chk({nm, " rst hi"},    128'(hiwater), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
`ifdef HEAP_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " clear ready"}, 128'(ready), 128'(0));
      chk({nm, " clear rsp"},   rsp,         128'(0));
    end
`endif
  endtask

  localparam logic [62:0] ROOT = 63'h1000_0000_0000_0005;

  vec_t vecs[14];
  vec_t v;
  logic [127:0] rnd;
  logic [125:0] d34, d56, dff;

  initial begin
    rstn = 1'b1;
    idle_inputs();
    #3;
    do_reset("init");
    chk("reset halted", 128'(halted), 128'(0));

    d34 = {63'h3, 63'h4};
    d56 = {63'h5, 63'h6};
    dff = {63'h7FFF_0000_1234_5678, 63'h0000_ABCD_0000_0001};
    vecs[0]  = mkv(1, ROOT, 0, 0, 30'd0,    '0,   0, {2'b01, ROOT, 63'b0}, 1, 0, 30'd0);
    vecs[1]  = mkv(0, '0,   0, 0, 30'd0,    '0,   0, 128'b0,              1, 0, 30'd0);
    vecs[2]  = mkv(0, '0,   1, 1, 30'd7,    d34,  0, 128'b0,              1, 0, 30'd8);
    vecs[3]  = mkv(0, '0,   1, 0, 30'd7,    '0,   0, {2'b10, d34},        1, 0, 30'd8);
    vecs[4]  = mkv(0, '0,   1, 0, 30'd1024, '0,   0, {2'b11, 126'b0},     1, 1, 30'd8);
    vecs[5]  = mkv(0, '0,   1, 0, 30'd7,    '0,   0, {2'b10, d34},        1, 1, 30'd8);
    vecs[6]  = mkv(0, '0,   1, 1, 30'd1023, dff,  0, 128'b0,              1, 1, 30'd1024);
    vecs[7]  = mkv(0, '0,   1, 1, 30'd2,    d56,  0, 128'b0,              1, 1, 30'd1024);
    vecs[8]  = mkv(0, '0,   1, 0, 30'd1023, '0,   0, {2'b10, dff},        1, 1, 30'd1024);
    vecs[9]  = mkv(0, '0,   1, 1, 30'd1031, dff,  0, {2'b11, 126'b0},     1, 1, 30'd1024);
    vecs[10] = mkv(0, '0,   1, 0, 30'd7,    '0,   0, {2'b10, d34},        1, 1, 30'd1024);
    vecs[11] = mkv(0, '0,   1, 1, 30'd7,    d56,  0, 128'b0,              1, 1, 30'd1024);
    vecs[12] = mkv(0, '0,   1, 0, 30'd7,    '0,   0, {2'b10, d56},        1, 1, 30'd1024);
    vecs[13] = mkv(1, 63'h5, 0, 0, 30'd0,   '0,   0, 128'b0,              1, 1, 30'd1024);
    for (int i = 0; i < 14; i++) cyc(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Randomized RUN traffic, mostly on a small address window so reads hit
    // previously written cells, with occasional out-of-range and top cells.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      v = mkv($urandom_range(0, 15) == 0, 63'(rnd), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, 30'd0, rnd[125:0], 0, '0, 0, 0, '0);
      case ($urandom_range(0, 15))
        0:       v.addr = 30'(DEPTH) + 30'($urandom_range(0, 1 << 28));
        1:       v.addr = 30'(DEPTH - 1 - $urandom_range(0, 3));
        default: v.addr = 30'($urandom_range(0, 31));
      endcase
      cyc(v, 1'b0, "rand");
    end

    // Halt beats a simultaneous write; afterwards everything is ignored.
    cyc(mkv(0, '0, 1, 1, 30'd3, d34, 0, '0, 0, 0, '0), 1'b0, "pre3");
    cyc(mkv(0, '0, 1, 1, 30'd3, dff, 1, '0, 0, 0, '0), 1'b0, "haltw");
    for (int i = 0; i < 6; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cyc(mkv(i % 2 == 0, 63'(rnd), 1, i % 3 == 0, 30'(i), rnd[125:0], 0, '0, 0, 0, '0),
          1'b0, "halted");
    end

    // Fresh run, then asynchronous reset asserted between clock edges.
    do_reset("second");
    cyc(mkv(1, 63'h2A, 0, 0, '0, '0, 0, '0, 0, 0, '0), 1'b0, "boot2");
`ifdef HEAP_CLEAR_EN
    cyc(mkv(0, '0, 1, 0, 30'd3, '0, 0, '0, 0, 0, '0), 1'b0, "read3clr");
`endif
    cyc(mkv(0, '0, 1, 1, 30'd9, dff, 0, '0, 0, 0, '0), 1'b0, "wr9");
    cyc(mkv(0, '0, 1, 0, 30'h2000_0000, '0, 0, '0, 0, 0, '0), 1'b0, "oor");
    cyc(mkv(0, '0, 1, 0, 30'd9, '0, 0, '0, 0, 0, '0), 1'b0, "rd9");
    #2;
    rstn = 1'b0;
    #1;
    chk("async rsp",    rsp,           128'(0));
    chk("async ready",  128'(ready),   128'(0));
    chk("async err",    128'(err),     128'(0));
    chk("async hi",     128'(hiwater), 128'(0));
    chk("async halted", 128'(halted),  128'(0));
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
